// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM frame-buffer arbiter: FSM state encoding,
// default bus widths and the SRAM strobe bundle with its canned values.
package sram_arb_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_WREC  = 2'd3
  } arb_state_t;

  // Active-low SRAM control strobes, kept together so they update as one register.
  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic ub_n;
    logic lb_n;
  } sram_strobe_t;

  // All strobes released: chip deselected, no output drive, no write.
  localparam sram_strobe_t STROBE_IDLE = 5'b11111;
  // Full-word read: chip and output enabled, both bytes, write disabled.
  localparam sram_strobe_t STROBE_READ = 5'b00100;

  // Write strobes for a given byte-enable pair ([1] upper, [0] lower).
  function automatic sram_strobe_t write_strobe(input logic [1:0] be);
    sram_strobe_t s;
    s.ce_n = 1'b0;
    s.oe_n = 1'b1;
    s.we_n = 1'b0;
    s.ub_n = ~be[1];
    s.lb_n = ~be[0];
    return s;
  endfunction

endpackage

// File: rtl/sram_frame_arbiter.sv
// Two-port arbiter sharing one asynchronous SRAM between a display reader and
// a video-in writer. Reads win by default; a write that has watched
// STARVE_MAX consecutive read grants is forced through next. All SRAM pins
// come straight from flops so nothing glitches on the board.
module sram_frame_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        wr_be,
  output logic              wr_gnt,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [DATA_W-1:0] SRAM_DQ_O,
  output logic              SRAM_DQ_OE,
  input  logic [DATA_W-1:0] SRAM_DQ_I,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);

  arb_state_t          state_r;
  sram_strobe_t        strobe_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   dq_o_r;
  logic                dq_oe_r;
  logic                rd_valid_r;
  logic [DATA_W-1:0]   rd_data_r;
  logic [STARVE_W-1:0] starve_cnt_r;

  logic                write_forced_s;

  assign write_forced_s = (starve_cnt_r == STARVE_LIM);

  // Grant decision, only in IDLE; reset forces both grants low.
  always_comb begin
    rd_gnt = 1'b0;
    wr_gnt = 1'b0;
    if (reset_n && (state_r == ST_IDLE)) begin
      if (rd_req && (!wr_req || !write_forced_s)) begin
        rd_gnt = 1'b1;
      end else if (wr_req) begin
        wr_gnt = 1'b1;
      end else begin
        rd_gnt = 1'b0;
        wr_gnt = 1'b0;
      end
    end else begin
      rd_gnt = 1'b0;
      wr_gnt = 1'b0;
    end
  end

  // Counts reads granted past a waiting write; any gap in wr_req forgets history.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_r <= {STARVE_W{1'b0}};
    end else if (wr_gnt || !wr_req) begin
      starve_cnt_r <= {STARVE_W{1'b0}};
    end else if (rd_gnt && !write_forced_s) begin
      starve_cnt_r <= starve_cnt_r + STARVE_ONE;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Transaction FSM; every SRAM pin and the read return path are loaded here.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      strobe_r   <= STROBE_IDLE;
      addr_r     <= {ADDR_W{1'b0}};
      dq_o_r     <= {DATA_W{1'b0}};
      dq_oe_r    <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= {DATA_W{1'b0}};
    end else begin
      rd_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (rd_gnt) begin
            addr_r   <= rd_addr;
            strobe_r <= STROBE_READ;
            dq_oe_r  <= 1'b0;
            state_r  <= ST_READ;
          end else if (wr_gnt) begin
            addr_r   <= wr_addr;
            dq_o_r   <= wr_data;
            strobe_r <= write_strobe(wr_be);
            dq_oe_r  <= 1'b1;
            state_r  <= ST_WRITE;
          end else begin
            strobe_r <= STROBE_IDLE;
            dq_oe_r  <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        ST_READ: begin
          // Data has had a full cycle of access time; capture and release.
          rd_data_r  <= SRAM_DQ_I;
          rd_valid_r <= 1'b1;
          strobe_r   <= STROBE_IDLE;
          dq_oe_r    <= 1'b0;
          state_r    <= ST_IDLE;
        end
        ST_WRITE: begin
          // Rising WE_N latches the write; keep address, data and drive for hold.
          strobe_r.we_n <= 1'b1;
          dq_oe_r       <= 1'b1;
          state_r       <= ST_WREC;
        end
        ST_WREC: begin
          strobe_r <= STROBE_IDLE;
          dq_oe_r  <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          strobe_r <= STROBE_IDLE;
          dq_oe_r  <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign SRAM_ADDR  = addr_r;
  assign SRAM_DQ_O  = dq_o_r;
  assign SRAM_DQ_OE = dq_oe_r;
  assign SRAM_CE_N  = strobe_r.ce_n;
  assign SRAM_OE_N  = strobe_r.oe_n;
  assign SRAM_WE_N  = strobe_r.we_n;
  assign SRAM_UB_N  = strobe_r.ub_n;
  assign SRAM_LB_N  = strobe_r.lb_n;
  assign rd_valid   = rd_valid_r;
  assign rd_data    = rd_data_r;

endmodule

// File: doc/sram_frame_arbiter.md
SRAM_FRAME_ARBITER -- requirements
Module: sram_frame_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  - ADDR_W, 20, SRAM word-address width.
  - DATA_W, 16, SRAM data width.
  - STARVE_MAX, 8, maximum consecutive read grants while a write is pending.
REQ-002 Ports, one per line: name, direction, width, meaning.
  - CLOCK_50, in, 1, the single clock; one clock, no other clock domains.
  - reset_n, in, 1, asynchronous active-low reset.
  - rd_req, in, 1, display read request.
  - rd_addr, in, ADDR_W, display read address.
  - rd_gnt, out, 1, read accepted this cycle.
  - rd_valid, out, 1, rd_data valid, one-cycle pulse.
  - rd_data, out, DATA_W, read data.
  - wr_req, in, 1, video-in write request.
  - wr_addr, in, ADDR_W, write address.
  - wr_data, in, DATA_W, write data.
  - wr_be, in, 2, byte enables: [1] upper byte, [0] lower byte.
  - wr_gnt, out, 1, write accepted this cycle.
  - SRAM_ADDR, out, ADDR_W, SRAM address.
  - SRAM_DQ_O, out, DATA_W, SRAM write data.
  - SRAM_DQ_OE, out, 1, tri-state enable; the top level drives SRAM_DQ only when this is 1.
  - SRAM_DQ_I, in, DATA_W, SRAM read data.
  - SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, out, 1 each, SRAM strobes, active-low.

Function
REQ-003 FSM states: IDLE, READ, WRITE, WREC. Arbitration takes place only in IDLE.
REQ-004 In IDLE, rd_gnt and wr_gnt are combinational and mutually exclusive.
  - At most one grant per IDLE cycle.
  - A granted request's address, data and byte enables are captured on that clock edge.
REQ-005 Arbitration priority:
  - If rd_req and wr_req are both high, read wins unless starve_cnt == STARVE_MAX, in which case write wins.
  - A single requester always wins.
REQ-006 starve_cnt rules:
  - Increments on each rd_gnt while wr_req is high; saturates at STARVE_MAX.
  - Clears on wr_gnt, or on any cycle with wr_req low.
REQ-007 Read transaction: IDLE(grant) -> READ -> IDLE.
  - In READ: SRAM_ADDR = captured address, CE_N=0, OE_N=0, UB_N=0, LB_N=0, WE_N=1, DQ_OE=0.
  - SRAM_DQ_I is registered at the end of READ.
  - rd_valid is high with rd_data exactly 2 cycles after the rd_gnt cycle.
REQ-008 Write transaction: IDLE(grant) -> WRITE -> WREC -> IDLE.
  - WRITE: CE_N=0, WE_N=0, OE_N=1, DQ_OE=1, UB_N=~wr_be[1], LB_N=~wr_be[0].
  - WREC: WE_N=1, DQ_OE=1, address and data held (hold time and bus turnaround).
REQ-009 Throughput:
  - Back-to-back reads: one grant every 2 cycles.
  - Back-to-back writes: one grant every 3 cycles.
REQ-010 All SRAM strobe, address, DQ_O and DQ_OE outputs are registered (no combinational glitches on the pins).
REQ-011 In IDLE, all strobes are high and DQ_OE=0; SRAM_ADDR holds its last value.
REQ-012 Requester rules:
  - A requester holds req and its fields stable until its grant.
  - Dropping req before the grant is legal; no access results.
  - Requests outside IDLE are ignored; no grant is issued until the FSM returns to IDLE.
REQ-013 rd_data holds its last value between rd_valid pulses.
REQ-014 Address 2^ADDR_W-1 is a legal address; no address arithmetic is performed, so no wrap-around occurs.

Reset
REQ-015 While reset_n=0:
  - State = IDLE, starve_cnt = 0.
  - SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N = 1.
  - SRAM_ADDR = 0, SRAM_DQ_O = 0, SRAM_DQ_OE = 0.
  - rd_gnt, wr_gnt, rd_valid = 0; rd_data = 0.
REQ-016 Reset asserted mid-transaction aborts it immediately (asynchronously).
  - Strobes are released at once.
  - No rd_valid is produced for the aborted read.
  - The first grant is possible in the first cycle after reset_n deasserts.

Structure
REQ-017 A shared package sram_arb_pkg holds the state enumeration, ADDR_W and DATA_W defaults, and the strobe-idle constant.
REQ-018 Single module; no sub-module. The starve counter and FSM stay inline.

Verification
REQ-019 Single read: rd_req=1, rd_addr=0x00123, SRAM model returns 0xBEEF.
  - Required: rd_gnt at cycle 0; CE_N=OE_N=0 at cycle 1; rd_valid=1 and rd_data=0xBEEF at cycle 2.
REQ-020 Single write: wr_addr=0xFFFFF, wr_data=0x5A5A, wr_be=2'b01.
  - Required: WE_N=0 for exactly one cycle; LB_N=0, UB_N=1; DQ_OE=1 for 2 cycles.
  - The model holds 0x5A in the low byte and the upper byte is unchanged.
REQ-021 Starvation: rd_req and wr_req held high continuously.
  - Required: 8 rd_gnt pulses, then 1 wr_gnt, then the pattern repeats.
  - starve_cnt never exceeds 8.
REQ-022 Simultaneous request with starve_cnt=0.
  - Required: read granted first; the write is granted at the first IDLE where rd_req=0.
REQ-023 Reset mid-write: reset_n=0 during WRITE.
  - Required: WE_N=1 and DQ_OE=0 asynchronously within the same cycle; no further strobes.
  - After release, a pending rd_req is granted in the first cycle.
REQ-024 Request withdrawal: rd_req pulsed high for one cycle while the FSM is in WREC.
  - Required: no rd_gnt, no SRAM access, no rd_valid.
